// File: rtl/icache_resp_d.sv
// icache_resp_d: dual-slot instruction fetch responder. Direct-mapped cache with
// 8-word burst refill; uncached fetches use single-word reads and never allocate.
module icache_resp_d #(
  parameter int unsigned NUM_LINES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc,
  input  logic [1:0]       inst_en,
  input  logic             uncache_en,
  input  logic             front_is_exception,
  input  logic [6:0]       front_exception_cause,
  input  logic             flush,
  output logic             stall,
  output logic [31:0]      pc_for_bpu,
  output logic [1:0][31:0] inst,
  output logic             stall_for_buffer,
  output logic [31:0]      pc_for_buffer,
  output logic [1:0][31:0] inst_for_buffer,
  output logic [1:0]       icache_fetch_inst_en,
  output logic             icache_is_exception,
  output logic [6:0]       icache_exception_cause,
  output logic             mem_rd_req,
  output logic [31:0]      mem_rd_addr,
  output logic             mem_rd_uncached,
  input  logic             mem_rd_ready,
  input  logic             mem_rd_valid,
  input  logic [31:0]      mem_rd_data,
  input  logic             mem_rd_last
);
  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = 32 - 5 - IDX_W;

  typedef enum logic [2:0] {S_IDLE, S_MISS_REQ, S_REFILL, S_UNC_REQ, S_UNC_WAIT} state_t;

  state_t               state_q, state_d;
  logic                 s1_valid_q, s1_valid_d;
  logic [31:0]          s1_pc_q, s1_pc_d;
  logic [1:0]           s1_en_q, s1_en_d;
  logic                 s1_unc_q, s1_unc_d;
  logic                 s1_exc_q, s1_exc_d;
  logic [6:0]           s1_cause_q, s1_cause_d;
  logic                 out_valid_q, out_valid_d;
  logic [31:0]          out_pc_q, out_pc_d;
  logic [1:0][31:0]     out_inst_q, out_inst_d;
  logic [1:0]           out_en_q, out_en_d;
  logic                 out_exc_q, out_exc_d;
  logic [6:0]           out_cause_q, out_cause_d;
  logic [31:0]          addr_q, addr_d;
  logic [2:0]           beat_q, beat_d;
  logic                 slot_q, slot_d;
  logic                 kill_q, kill_d;
  logic [1:0][31:0]     unc_data_q, unc_data_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;

  logic [31:0]      data_mem [NUM_LINES*8];
  logic [TAG_W-1:0] tag_mem  [NUM_LINES];

  logic [IDX_W-1:0] s1_idx, fill_idx;
  logic [TAG_W-1:0] s1_tag, fill_tag;
  logic             line_cross, hit, s1_done, serviced, unc_finish, refill_we;
  logic [1:0]       s1_en_eff;
  logic [1:0][31:0] hit_inst;

  assign s1_idx     = s1_pc_q[IDX_W+4:5];
  assign s1_tag     = s1_pc_q[31:IDX_W+5];
  assign fill_idx   = addr_q[IDX_W+4:5];
  assign fill_tag   = addr_q[31:IDX_W+5];
  assign line_cross = (s1_pc_q[4:2] == 3'd7);
  assign s1_en_eff  = line_cross ? {1'b0, s1_en_q[0]} : s1_en_q;
  assign hit        = valid_q[s1_idx] && (tag_mem[s1_idx] == s1_tag);
  // Exceptions and empty slot sets complete in IDLE without touching memory.
  assign s1_done    = s1_exc_q || (s1_en_eff == 2'b00) || (!s1_unc_q && hit);
  assign serviced   = (state_q == S_IDLE) && s1_valid_q && s1_done;
  assign stall      = s1_valid_q && ((state_q != S_IDLE) || !s1_done);
  assign refill_we  = (state_q == S_REFILL) && mem_rd_valid;

  always_comb begin
    hit_inst = '0;
    if (s1_en_eff[0]) hit_inst[0] = data_mem[{s1_idx, s1_pc_q[4:2]}];
    if (s1_en_eff[1]) hit_inst[1] = data_mem[{s1_idx, s1_pc_q[4:2] + 3'd1}];
  end

  assign pc_for_bpu             = s1_pc_q;
  assign inst                   = (s1_valid_q && hit && !s1_exc_q) ? hit_inst : '0;
  assign stall_for_buffer       = !out_valid_q;
  assign pc_for_buffer          = out_pc_q;
  assign inst_for_buffer        = out_inst_q;
  assign icache_fetch_inst_en   = out_en_q;
  assign icache_is_exception    = out_exc_q;
  assign icache_exception_cause = out_cause_q;
  assign mem_rd_req             = (state_q == S_MISS_REQ) || (state_q == S_UNC_REQ);
  assign mem_rd_addr            = addr_q;
  assign mem_rd_uncached        = (state_q == S_UNC_REQ);

  always_comb begin
    state_d     = state_q;
    s1_valid_d  = s1_valid_q;
    s1_pc_d     = s1_pc_q;
    s1_en_d     = s1_en_q;
    s1_unc_d    = s1_unc_q;
    s1_exc_d    = s1_exc_q;
    s1_cause_d  = s1_cause_q;
    out_valid_d = 1'b0;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    out_en_d    = out_en_q;
    out_exc_d   = out_exc_q;
    out_cause_d = out_cause_q;
    addr_d      = addr_q;
    beat_d      = beat_q;
    slot_d      = slot_q;
    kill_d      = kill_q;
    unc_data_d  = unc_data_q;
    valid_d     = valid_q;
    unc_finish  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (s1_valid_q && !flush && !s1_done) begin
          if (s1_unc_q) begin
            state_d = S_UNC_REQ;
            slot_d  = ~s1_en_eff[0];
            addr_d  = s1_pc_q + (s1_en_eff[0] ? 32'd0 : 32'd4);
          end else begin
            state_d = S_MISS_REQ;
            addr_d  = {s1_pc_q[31:5], 5'b0};
          end
        end
      end
      S_MISS_REQ: begin
        if (mem_rd_ready) begin
          state_d = S_REFILL;
          beat_d  = '0;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_REFILL: begin
        if (mem_rd_valid) begin
          beat_d = beat_q + 3'd1;
          if (mem_rd_last) begin
            valid_d[fill_idx] = 1'b1;
            state_d           = S_IDLE;
          end
        end
      end
      S_UNC_REQ: begin
        if (mem_rd_ready) state_d = S_UNC_WAIT;
        else if (flush)   state_d = S_IDLE;
      end
      S_UNC_WAIT: begin
        if (mem_rd_valid) begin
          unc_data_d[slot_q] = mem_rd_data;
          if (kill_q || flush) begin
            state_d = S_IDLE;
          end else if (!slot_q && s1_en_eff[1]) begin
            state_d = S_UNC_REQ;
            slot_d  = 1'b1;
            addr_d  = s1_pc_q + 32'd4;
          end else begin
            state_d    = S_IDLE;
            unc_finish = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A flushed transaction still drains its beats; kill marks its data as stale.
    if (flush && (state_q != S_IDLE)) kill_d = 1'b1;
    if (state_d == S_IDLE) kill_d = 1'b0;

    if (flush) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (serviced) begin
        out_valid_d = 1'b1;
        out_pc_d    = s1_pc_q;
        out_exc_d   = s1_exc_q;
        out_cause_d = s1_cause_q;
        out_en_d    = s1_exc_q ? s1_en_q : s1_en_eff;
        out_inst_d  = s1_exc_q ? '0 : hit_inst;
      end else if (unc_finish) begin
        out_valid_d   = 1'b1;
        out_pc_d      = s1_pc_q;
        out_exc_d     = 1'b0;
        out_cause_d   = '0;
        out_en_d      = s1_en_eff;
        out_inst_d[0] = s1_en_eff[0] ? (slot_q ? unc_data_q[0] : mem_rd_data) : '0;
        out_inst_d[1] = s1_en_eff[1] ? mem_rd_data : '0;
        s1_valid_d    = 1'b0;
      end
      if (!stall) begin
        s1_valid_d = |inst_en;
        if (|inst_en) begin
          s1_pc_d    = pc;
          s1_en_d    = inst_en;
          s1_unc_d   = uncache_en;
          s1_exc_d   = front_is_exception;
          s1_cause_d = front_exception_cause;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      s1_valid_q  <= 1'b0;
      s1_pc_q     <= '0;
      s1_en_q     <= '0;
      s1_unc_q    <= 1'b0;
      s1_exc_q    <= 1'b0;
      s1_cause_q  <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_inst_q  <= '0;
      out_en_q    <= '0;
      out_exc_q   <= 1'b0;
      out_cause_q <= '0;
      addr_q      <= '0;
      beat_q      <= '0;
      slot_q      <= 1'b0;
      kill_q      <= 1'b0;
      unc_data_q  <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      s1_valid_q  <= s1_valid_d;
      s1_pc_q     <= s1_pc_d;
      s1_en_q     <= s1_en_d;
      s1_unc_q    <= s1_unc_d;
      s1_exc_q    <= s1_exc_d;
      s1_cause_q  <= s1_cause_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      out_en_q    <= out_en_d;
      out_exc_q   <= out_exc_d;
      out_cause_q <= out_cause_d;
      addr_q      <= addr_d;
      beat_q      <= beat_d;
      slot_q      <= slot_d;
      kill_q      <= kill_d;
      unc_data_q  <= unc_data_d;
      valid_q     <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (refill_we) data_mem[{fill_idx, beat_q}] <= mem_rd_data;
    if (refill_we && mem_rd_last) tag_mem[fill_idx] <= fill_tag;
  end
endmodule

// File: tb/tb_icache_resp_d.sv
// Scoreboard bench for icache_resp_d: directed fetches against a burst memory model
// whose word at address a is a + 0x1000_0000.
module tb_icache_resp_d;
  logic             clk, rst;
  logic [31:0]      pc;
  logic [1:0]       inst_en;
  logic             uncache_en, front_is_exception, flush;
  logic [6:0]       front_exception_cause;
  logic             stall, stall_for_buffer;
  logic [31:0]      pc_for_bpu, pc_for_buffer;
  logic [1:0][31:0] inst, inst_for_buffer;
  logic [1:0]       icache_fetch_inst_en;
  logic             icache_is_exception;
  logic [6:0]       icache_exception_cause;
  logic             mem_rd_req, mem_rd_uncached, mem_rd_ready, mem_rd_valid, mem_rd_last;
  logic [31:0]      mem_rd_addr, mem_rd_data;

  icache_resp_d #(.NUM_LINES(64)) dut (
    .clk(clk), .rst(rst), .pc(pc), .inst_en(inst_en), .uncache_en(uncache_en),
    .front_is_exception(front_is_exception), .front_exception_cause(front_exception_cause),
    .flush(flush), .stall(stall), .pc_for_bpu(pc_for_bpu), .inst(inst),
    .stall_for_buffer(stall_for_buffer), .pc_for_buffer(pc_for_buffer),
    .inst_for_buffer(inst_for_buffer), .icache_fetch_inst_en(icache_fetch_inst_en),
    .icache_is_exception(icache_is_exception), .icache_exception_cause(icache_exception_cause),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_uncached(mem_rd_uncached),
    .mem_rd_ready(mem_rd_ready), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .mem_rd_last(mem_rd_last)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [1:0]  en;
    logic        exc;
    logic [6:0]  cause;
  } out_t;
  typedef struct {
    logic [31:0] addr;
    logic        unc;
  } req_t;

  out_t exp_q[$];
  req_t exp_req[$];
  int   out_cyc[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, out_cnt = 0, req_cnt = 0, cur_beat = 0, last_beat_cyc = 0;
  bit   mem_busy = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic out_t mk_out(input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                                  input logic [1:0] e, input logic x, input logic [6:0] c);
    out_t o;
    o.pc = p; o.i0 = a; o.i1 = b; o.en = e; o.exc = x; o.cause = c;
    return o;
  endfunction

  function automatic req_t mk_req(input logic [31:0] a, input logic u);
    req_t r;
    r.addr = a; r.unc = u;
    return r;
  endfunction

  function automatic int get_cyc(input int k);
    if (k < out_cyc.size()) return out_cyc[k];
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Burst memory: accept one request, then stream 8 beats (cached) or 1 beat (uncached).
  initial begin : mem_model
    logic [31:0] a;
    int n;
    mem_rd_ready = 0; mem_rd_valid = 0; mem_rd_data = '0; mem_rd_last = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst && mem_rd_req) begin
        mem_busy = 1;
        a = mem_rd_addr;
        n = mem_rd_uncached ? 1 : 8;
        mem_rd_ready = 1;
        @(posedge clk); #1;
        mem_rd_ready = 0;
        for (int i = 0; i < n; i++) begin
          cur_beat     = i;
          mem_rd_valid = 1;
          mem_rd_data  = a + 32'(4 * i) + 32'h1000_0000;
          mem_rd_last  = (i == n - 1);
          @(posedge clk); #1;
        end
        last_beat_cyc = cyc;
        mem_rd_valid = 0; mem_rd_last = 0;
        mem_busy = 0;
      end
    end
  end

  initial begin : req_monitor
    req_t e;
    forever begin
      @(negedge clk);
      if (!rst && mem_rd_req && mem_rd_ready) begin
        req_cnt++;
        checks++;
        if (exp_req.size() == 0) begin
          errors++;
          $display("FAIL req_unexpected actual addr=%h unc=%b required none", mem_rd_addr, mem_rd_uncached);
        end else begin
          e = exp_req.pop_front();
          if (mem_rd_addr !== e.addr || mem_rd_uncached !== e.unc) begin
            errors++;
            $display("FAIL req_%0d actual addr=%h unc=%b required addr=%h unc=%b",
                     req_cnt, mem_rd_addr, mem_rd_uncached, e.addr, e.unc);
          end
        end
      end
    end
  end

  initial begin : out_monitor
    out_t e;
    forever begin
      @(negedge clk);
      if (!rst && !stall_for_buffer) begin
        out_cyc.push_back(cyc);
        out_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected actual pc=%h en=%b required none", pc_for_buffer, icache_fetch_inst_en);
        end else begin
          e = exp_q.pop_front();
          if (pc_for_buffer !== e.pc || inst_for_buffer[0] !== e.i0 || inst_for_buffer[1] !== e.i1 ||
              icache_fetch_inst_en !== e.en || icache_is_exception !== e.exc ||
              icache_exception_cause !== e.cause) begin
            errors++;
            $display("FAIL out_%0d actual pc=%h i0=%h i1=%h en=%b exc=%b cause=%h required pc=%h i0=%h i1=%h en=%b exc=%b cause=%h",
                     out_cnt, pc_for_buffer, inst_for_buffer[0], inst_for_buffer[1], icache_fetch_inst_en,
                     icache_is_exception, icache_exception_cause, e.pc, e.i0, e.i1, e.en, e.exc, e.cause);
          end
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [1:0] en, input logic u, input logic ex,
                       input logic [6:0] c, output int acc);
    bit ok;
    ok = 0;
    pc = a; inst_en = en; uncache_en = u; front_is_exception = ex; front_exception_cause = c;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!stall) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL issue_timeout pc=%h actual stall=%b required 0", a, stall);
    end
    @(posedge clk); #1;
    acc = cyc;
    inst_en = 0; uncache_en = 0; front_is_exception = 0; front_exception_cause = 0;
  endtask

  task automatic wait_outs(input int n);
    bit ok;
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (out_cnt >= n) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_outs actual=%0d required=%0d", out_cnt, n);
    end
  endtask

  initial begin : stim
    int acc_a, acc_b, reqs0;
    bit ok;
    rst = 1; pc = 0; inst_en = 0; uncache_en = 0; front_is_exception = 0;
    front_exception_cause = 0; flush = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_stall_for_buffer", 64'(stall_for_buffer), 64'd1);
    chk("rst_mem_rd_req", 64'(mem_rd_req), 64'd0);
    chk("rst_pc_for_buffer", 64'(pc_for_buffer), 64'd0);
    chk("rst_inst_for_buffer", 64'(inst_for_buffer), 64'd0);
    chk("rst_fetch_inst_en", 64'(icache_fetch_inst_en), 64'd0);
    chk("rst_mem_rd_addr", 64'(mem_rd_addr), 64'd0);
    @(posedge clk); #1;

    // Cold miss: one line refill, result = beats 0 and 1.
    exp_req.push_back(mk_req(32'h1C00_0000, 1'b0));
    exp_q.push_back(mk_out(32'h1C00_0000, 32'h2C00_0000, 32'h2C00_0004, 2'b11, 1'b0, 7'h00));
    issue(32'h1C00_0000, 2'b11, 1'b0, 1'b0, 7'h00, acc_a);
    @(negedge clk);
    chk("miss_stall", 64'(stall), 64'd1);
    wait_outs(1);
    chk("miss_latency", 64'(get_cyc(0)), 64'(last_beat_cyc + 1));
    @(posedge clk); #1;

    // Back-to-back hits.
    reqs0 = req_cnt;
    exp_q.push_back(mk_out(32'h1C00_0008, 32'h2C00_0008, 32'h2C00_000C, 2'b11, 1'b0, 7'h00));
    exp_q.push_back(mk_out(32'h1C00_0010, 32'h2C00_0010, 32'h2C00_0014, 2'b11, 1'b0, 7'h00));
    issue(32'h1C00_0008, 2'b11, 1'b0, 1'b0, 7'h00, acc_a);
    chk("bpu_pc", 64'(pc_for_bpu), 64'h1C00_0008);
    chk("bpu_inst0", 64'(inst[0]), 64'h2C00_0008);
    chk("hit_stall", 64'(stall), 64'd0);
    issue(32'h1C00_0010, 2'b11, 1'b0, 1'b0, 7'h00, acc_b);
    wait_outs(3);
    chk("hit_latency", 64'(get_cyc(1)), 64'(acc_a + 1));
    chk("hit_back_to_back", 64'(get_cyc(2)), 64'(acc_a + 2));
    chk("hit_no_req", 64'(req_cnt), 64'(reqs0));
    @(posedge clk); #1;

    // Line crossing: slot 1 dropped.
    exp_q.push_back(mk_out(32'h1C00_001C, 32'h2C00_001C, 32'h0, 2'b01, 1'b0, 7'h00));
    issue(32'h1C00_001C, 2'b11, 1'b0, 1'b0, 7'h00, acc_a);
    wait_outs(4);
    @(posedge clk); #1;

    // Uncached two-slot fetch, then a cached fetch of the same address still misses.
    exp_req.push_back(mk_req(32'hBFC0_0000, 1'b1));
    exp_req.push_back(mk_req(32'hBFC0_0004, 1'b1));
    exp_q.push_back(mk_out(32'hBFC0_0000, 32'hCFC0_0000, 32'hCFC0_0004, 2'b11, 1'b0, 7'h00));
    issue(32'hBFC0_0000, 2'b11, 1'b1, 1'b0, 7'h00, acc_a);
    wait_outs(5);
    chk("unc_latency", 64'(get_cyc(4)), 64'(last_beat_cyc));
    @(posedge clk); #1;
    exp_req.push_back(mk_req(32'hBFC0_0000, 1'b0));
    exp_q.push_back(mk_out(32'hBFC0_0000, 32'hCFC0_0000, 32'h0, 2'b01, 1'b0, 7'h00));
    issue(32'hBFC0_0000, 2'b01, 1'b0, 1'b0, 7'h00, acc_a);
    wait_outs(6);
    @(posedge clk); #1;

    // Flush on refill beat 3: line still installed, no output; refetch then hits.
    exp_req.push_back(mk_req(32'h1C00_0040, 1'b0));
    issue(32'h1C00_0040, 2'b11, 1'b0, 1'b0, 7'h00, acc_a);
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #2;
      if (mem_rd_valid && cur_beat == 3) begin
        ok = 1;
        break;
      end
    end
    chk("flush_beat3_seen", 64'(ok), 64'd1);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (!mem_busy) begin
        ok = 1;
        break;
      end
    end
    chk("flush_refill_drained", 64'(ok), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("flush_no_output", 64'(out_cnt), 64'd6);
    reqs0 = req_cnt;
    exp_q.push_back(mk_out(32'h1C00_0040, 32'h2C00_0040, 32'h2C00_0044, 2'b11, 1'b0, 7'h00));
    issue(32'h1C00_0040, 2'b11, 1'b0, 1'b0, 7'h00, acc_a);
    wait_outs(7);
    chk("refetch_hit_latency", 64'(get_cyc(6)), 64'(acc_a + 1));
    chk("refetch_no_req", 64'(req_cnt), 64'(reqs0));
    @(posedge clk); #1;

    // Exception request: forwarded without a memory access.
    reqs0 = req_cnt;
    exp_q.push_back(mk_out(32'h1C00_0100, 32'h0, 32'h0, 2'b11, 1'b1, 7'h08));
    issue(32'h1C00_0100, 2'b11, 1'b0, 1'b1, 7'h08, acc_a);
    wait_outs(8);
    chk("exc_latency", 64'(get_cyc(7)), 64'(acc_a + 1));
    chk("exc_no_req", 64'(req_cnt), 64'(reqs0));

    repeat (5) @(posedge clk);
    #1;
    chk("exp_out_drained", 64'(exp_q.size()), 64'd0);
    chk("exp_req_drained", 64'(exp_req.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
